// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants, also used by the transmitter.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int OVS = 16;  // oversample ticks per bit
  localparam int MID = 7;   // tick index of the start-bit centre check

endpackage

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, with a selectable
// reset value so an idle-high line never looks like a start bit out of reset.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments make both flops capture on the same edge,
      // giving a true two-stage chain instead of a single collapsed flop.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled frame recovery (start, DBIT data LSB first,
// optional parity, stop) with a one-cycle completion strobe and error flags.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            rx_busy
);

  logic w_rx_s;

  rx_state_e       r_state,  w_state_next;
  logic [4:0]      r_s,      w_s_next;
  logic [2:0]      r_n,      w_n_next;
  logic [DBIT-1:0] r_b,      w_b_next;
  logic            r_p,      w_p_next;
  logic            r_perr,   w_perr_next;
  logic [DBIT-1:0] r_dout,   w_dout_next;
  logic            r_done,   w_done_next;
  logic            r_ferr,   w_ferr_next;
  logic            r_parerr, w_parerr_next;

  rx_sync #(.RST_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_n      <= '0;
      r_b      <= '0;
      r_p      <= 1'b0;
      r_perr   <= 1'b0;
      r_dout   <= '0;
      r_done   <= 1'b0;
      r_ferr   <= 1'b0;
      r_parerr <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_s      <= w_s_next;
      r_n      <= w_n_next;
      r_b      <= w_b_next;
      r_p      <= w_p_next;
      r_perr   <= w_perr_next;
      r_dout   <= w_dout_next;
      r_done   <= w_done_next;
      r_ferr   <= w_ferr_next;
      r_parerr <= w_parerr_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    w_state_next  = r_state;
    w_s_next      = r_s;
    w_n_next      = r_n;
    w_b_next      = r_b;
    w_p_next      = r_p;
    w_perr_next   = r_perr;
    w_dout_next   = r_dout;
    w_done_next   = 1'b0;
    w_ferr_next   = 1'b0;
    w_parerr_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = ST_START;
          w_s_next     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_s == 5'(MID)) begin
            // Line must still be low at the start-bit centre, else it was a glitch.
            if (!w_rx_s) begin
              w_state_next = ST_DATA;
              w_s_next     = '0;
              w_n_next     = '0;
              w_p_next     = (PAR_ODD != 0);
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_s == 5'(OVS - 1)) begin
            w_b_next = {w_rx_s, r_b[DBIT-1:1]};
            w_p_next = r_p ^ w_rx_s;
            w_s_next = '0;
            if (r_n == 3'(DBIT - 1)) begin
              w_state_next = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              w_n_next = r_n + 3'd1;
            end
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (r_s == 5'(OVS - 1)) begin
            w_perr_next  = r_p ^ w_rx_s;
            w_s_next     = '0;
            w_state_next = ST_STOP;
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (r_s == 5'(SB_TICK - 1)) begin
            w_dout_next   = r_b;
            w_ferr_next   = ~w_rx_s;
            w_parerr_next = r_perr;
            w_done_next   = 1'b1;
            w_state_next  = ST_IDLE;
          end else begin
            w_s_next = r_s + 5'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign parity_err   = r_parerr;
  assign rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1 instance and an 8E1 instance share
// clock, reset and a baud tick every 5 clk; frames are driven at 80 clk per bit.
module tb_uart_receiver;

  typedef struct {
    logic       sel;       // 0: 8N1 instance, 1: 8E1 instance
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;  // 0: stop held low across its centre
    logic       gap;       // idle time after the frame
    logic [7:0] exp_dout;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx0, rx1;
  logic [7:0] dout0, dout1;
  logic       done0, done1, ferr0, ferr1, perr0, perr1, busy0, busy1;

  int total = 0;
  int bad   = 0;
  int btb   = 0;
  int stale = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  vec_t vecs[9];

  uart_receiver #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .s_tick(s_tick),
    .rx_dout(dout0), .rx_done_tick(done0), .frame_err(ferr0),
    .parity_err(perr0), .rx_busy(busy0)
  );

  uart_receiver #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) u_dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .s_tick(s_tick),
    .rx_dout(dout1), .rx_done_tick(done1), .frame_err(ferr1),
    .parity_err(perr1), .rx_busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (4) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  // Strobe monitor: records each completed frame and flags wide strobes or
  // error flags lingering past the strobe cycle.
  always @(negedge clk) begin
    if (done0) q0.push_back({dout0, ferr0, perr0});
    if (done1) q1.push_back({dout1, ferr1, perr1});
    if (done0 && prev0) btb++;
    if (done1 && prev1) btb++;
    if (prev0 && !done0 && (ferr0 || perr0)) stale++;
    if (prev1 && !done1 && (ferr1 || perr1)) stale++;
    prev0 = done0;
    prev1 = done1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sel, input logic [7:0] data, input logic pb,
                              input logic stop, input logic gap, input logic [7:0] ed,
                              input logic ef, input logic ep);
    vec_t v;
    v.sel = sel; v.data = data; v.par_bit = pb; v.stop_bit = stop; v.gap = gap;
    v.exp_dout = ed; v.exp_ferr = ef; v.exp_perr = ep;
    return v;
  endfunction

  // Holds a line level for nclk clocks; every call starts and ends 1 time unit
  // after a rising edge, so tick phase stays fixed once aligned.
  task automatic drive_bit(input logic sel, input logic v, input int nclk);
    if (sel) rx1 = v;
    else     rx0 = v;
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] data, input logic pb,
                            input logic stop);
    drive_bit(sel, 1'b0, 80);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i], 80);
    if (sel) drive_bit(sel, pb, 80);
    if (stop) begin
      drive_bit(sel, 1'b1, 80);
    end else begin
      drive_bit(sel, 1'b0, 60);
      drive_bit(sel, 1'b1, 20);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int n;
    logic [9:0] rec;
    send_frame(v.sel, v.data, v.par_bit, v.stop_bit);
    if (v.gap) drive_bit(v.sel, 1'b1, 40);
    n = v.sel ? q1.size() : q0.size();
    check($sformatf("vec%0d_strobes", idx), n, 1);
    if (n > 0) begin
      if (v.sel) rec = q1.pop_front();
      else       rec = q0.pop_front();
      check($sformatf("vec%0d_dout", idx), rec[9:2], v.exp_dout);
      check($sformatf("vec%0d_ferr", idx), rec[1], v.exp_ferr);
      check($sformatf("vec%0d_perr", idx), rec[0], v.exp_perr);
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    vecs[0] = mk(0, 8'h55, 0, 1, 1, 8'h55, 0, 0);
    vecs[1] = mk(0, 8'hA3, 0, 1, 0, 8'hA3, 0, 0);
    vecs[2] = mk(0, 8'h0F, 0, 1, 1, 8'h0F, 0, 0);
    vecs[3] = mk(0, 8'h81, 0, 0, 1, 8'h81, 1, 0);
    vecs[4] = mk(0, 8'h42, 0, 1, 1, 8'h42, 0, 0);
    vecs[5] = mk(1, 8'h07, 1, 1, 1, 8'h07, 0, 0);
    vecs[6] = mk(1, 8'h07, 0, 1, 1, 8'h07, 0, 1);
    vecs[7] = mk(1, 8'hC8, 1, 1, 1, 8'hC8, 0, 0);
    vecs[8] = mk(1, 8'hB6, 0, 1, 1, 8'hB6, 0, 1);

    reset = 1'b1;
    rx0   = 1'b1;
    rx1   = 1'b1;
    repeat (10) @(posedge clk);
    do @(posedge clk); while (s_tick !== 1'b1);
    #1 reset = 1'b0;

    check("rst_dout",  dout0, 8'h00);
    check("rst_done",  done0, 1'b0);
    check("rst_ferr",  ferr0, 1'b0);
    check("rst_perr",  perr0, 1'b0);
    check("rst_busy",  busy0, 1'b0);
    check("rst_busy1", busy1, 1'b0);

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

    // 6-tick low glitch on an idle line
    drive_bit(0, 1'b0, 10);
    check("glitch_busy_hi", busy0, 1'b1);
    drive_bit(0, 1'b0, 20);
    drive_bit(0, 1'b1, 60);
    check("glitch_busy_lo", busy0, 1'b0);
    check("glitch_no_strobe", q0.size(), 0);
    apply_vec(mk(0, 8'h3C, 0, 1, 1, 8'h3C, 0, 0), 9);

    // Reset in the middle of data bit 4 of 0xFF
    drive_bit(0, 1'b0, 80);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 80);
    drive_bit(0, 1'b1, 40);
    check("midrst_busy_before", busy0, 1'b1);
    check("midrst_dout_before", dout0, 8'h3C);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_dout", dout0, 8'h00);
    check("midrst_done", done0, 1'b0);
    check("midrst_dout1", dout1, 8'h00);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    drive_bit(0, 1'b1, 400);
    check("midrst_no_strobe", q0.size(), 0);
    check("midrst_idle", busy0, 1'b0);
    apply_vec(mk(0, 8'h12, 0, 1, 1, 8'h12, 0, 0), 10);

    check("strobe_single_cycle", btb, 0);
    check("err_flags_cleared", stale, 0);
    check("no_stray_strobes", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
